// File: rtl/pipe_ctrl_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_unit_if
// Brief    : IF/ID-side inputs and stage control outputs of pipe_ctrl_unit.
// Revision : 1.0
// ============================================================================
interface pipe_ctrl_unit_if #(
    parameter int ALU_OP_W = 3
);
    logic [5:0]          op_code;
    logic [5:0]          func;
    logic                no_op;
    logic                flush;

    logic                id_branch;
    logic                id_branch_n;
    logic                id_jump;
    logic                id_illegal;
    logic                mul_stall;

    logic                ex_reg_dst;
    logic                ex_alu_src;
    logic [ALU_OP_W-1:0] ex_alu_op;
    logic                ex_mul;
    logic                mem_read;
    logic                mem_write;
    logic                wb_reg_write;
    logic                wb_mem_to_reg;

    modport master (
        output op_code, func, no_op, flush,
        input  id_branch, id_branch_n, id_jump, id_illegal, mul_stall,
        input  ex_reg_dst, ex_alu_src, ex_alu_op, ex_mul,
        input  mem_read, mem_write, wb_reg_write, wb_mem_to_reg
    );

    modport slave (
        input  op_code, func, no_op, flush,
        output id_branch, id_branch_n, id_jump, id_illegal, mul_stall,
        output ex_reg_dst, ex_alu_src, ex_alu_op, ex_mul,
        output mem_read, mem_write, wb_reg_write, wb_mem_to_reg
    );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_unit
// Brief    : Registered MIPS control: ID decode plus ID/EX, EX/MEM, MEM/WB
//            control bundles with bubble, flush and multi-cycle mult stall.
// Revision : 1.0
// ============================================================================
module pipe_ctrl_unit #(
    parameter int ALU_OP_W = 3,
    parameter int MUL_LAT  = 4,
    parameter int EN_IMM   = 1
) (
    input  logic             clk,
    input  logic             rst,
    pipe_ctrl_unit_if.slave  bus
);

    localparam int c_CNT_W = $clog2(MUL_LAT) + 1;
    localparam logic [c_CNT_W-1:0] c_MUL_LOAD = c_CNT_W'(MUL_LAT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    localparam logic [5:0] c_FN_ADD   = 6'b100000;
    localparam logic [5:0] c_FN_SUB   = 6'b100010;
    localparam logic [5:0] c_FN_AND   = 6'b100100;
    localparam logic [5:0] c_FN_OR    = 6'b100101;
    localparam logic [5:0] c_FN_SLT   = 6'b101010;
    localparam logic [5:0] c_FN_MULT  = 6'b011000;

    localparam logic [ALU_OP_W-1:0] c_ALU_ADD  = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] c_ALU_SUB  = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] c_ALU_FUNC = ALU_OP_W'(2);

    typedef struct packed {
        logic                reg_dst;
        logic                alu_src;
        logic [ALU_OP_W-1:0] alu_op;
        logic                mul;
        logic                mem_read;
        logic                mem_write;
        logic                reg_write;
        logic                mem_to_reg;
    } idex_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic mem_to_reg;
    } exmem_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } memwb_t;

    idex_t               w_dec;
    logic                w_branch;
    logic                w_branch_n;
    logic                w_jump;
    logic                w_illegal;
    logic                w_kill;
    logic                w_mul_stall;

    idex_t               idex_q,    idex_d;
    exmem_t              exmem_q,   exmem_d;
    memwb_t              memwb_q,   memwb_d;
    logic [c_CNT_W-1:0]  mul_cnt_q, mul_cnt_d;

    // Unknown op/func bits match no case item and fall into the illegal default.
    always_comb begin
        w_dec      = '0;
        w_branch   = 1'b0;
        w_branch_n = 1'b0;
        w_jump     = 1'b0;
        w_illegal  = 1'b0;
        case (bus.op_code)
            c_OP_RTYPE: begin
                case (bus.func)
                    c_FN_ADD, c_FN_SUB, c_FN_AND, c_FN_OR, c_FN_SLT: begin
                        w_dec.reg_write = 1'b1;
                        w_dec.reg_dst   = 1'b1;
                        w_dec.alu_op    = c_ALU_FUNC;
                    end
                    c_FN_MULT: begin
                        w_dec.mul    = 1'b1;
                        w_dec.alu_op = c_ALU_FUNC;
                    end
                    default: w_illegal = 1'b1;
                endcase
            end
            c_OP_LW: begin
                w_dec.reg_write  = 1'b1;
                w_dec.mem_read   = 1'b1;
                w_dec.mem_to_reg = 1'b1;
                w_dec.alu_src    = 1'b1;
                w_dec.alu_op     = c_ALU_ADD;
            end
            c_OP_SW: begin
                w_dec.mem_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_dec.alu_op    = c_ALU_ADD;
            end
            c_OP_ADDI: begin
                if (EN_IMM != 0) begin
                    w_dec.reg_write = 1'b1;
                    w_dec.alu_src   = 1'b1;
                    w_dec.alu_op    = c_ALU_ADD;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            c_OP_BEQ: begin
                w_branch     = 1'b1;
                w_dec.alu_op = c_ALU_SUB;
            end
            c_OP_BNE: begin
                w_branch_n   = 1'b1;
                w_dec.alu_op = c_ALU_SUB;
            end
            c_OP_J: begin
                w_jump = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_kill      = bus.no_op | bus.flush;
    assign w_mul_stall = (mul_cnt_q != '0);

    // Hazard requests are only honoured once the multiply has released ID/EX.
    always_comb begin
        idex_d    = idex_q;
        mul_cnt_d = mul_cnt_q;
        exmem_d   = '0;
        memwb_d   = '0;

        if (!w_mul_stall) begin
            if (w_kill) begin
                idex_d = '0;
            end else begin
                idex_d = w_dec;
            end
        end

        if (!w_mul_stall && !w_kill && w_dec.mul) begin
            mul_cnt_d = c_MUL_LOAD;
        end else if (w_mul_stall) begin
            mul_cnt_d = mul_cnt_q - c_CNT_ONE;
        end

        if (!w_mul_stall) begin
            exmem_d.mem_read   = idex_q.mem_read;
            exmem_d.mem_write  = idex_q.mem_write;
            exmem_d.reg_write  = idex_q.reg_write;
            exmem_d.mem_to_reg = idex_q.mem_to_reg;
        end

        memwb_d.reg_write  = exmem_q.reg_write;
        memwb_d.mem_to_reg = exmem_q.mem_to_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_q    <= '0;
            exmem_q   <= '0;
            memwb_q   <= '0;
            mul_cnt_q <= '0;
        end else begin
            idex_q    <= idex_d;
            exmem_q   <= exmem_d;
            memwb_q   <= memwb_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

    assign bus.id_branch     = w_branch   & ~w_kill;
    assign bus.id_branch_n   = w_branch_n & ~w_kill;
    assign bus.id_jump       = w_jump     & ~w_kill;
    assign bus.id_illegal    = w_illegal;
    assign bus.mul_stall     = w_mul_stall;

    assign bus.ex_reg_dst    = idex_q.reg_dst;
    assign bus.ex_alu_src    = idex_q.alu_src;
    assign bus.ex_alu_op     = idex_q.alu_op;
    assign bus.ex_mul        = idex_q.mul;
    assign bus.mem_read      = exmem_q.mem_read;
    assign bus.mem_write     = exmem_q.mem_write;
    assign bus.wb_reg_write  = memwb_q.reg_write;
    assign bus.wb_mem_to_reg = memwb_q.mem_to_reg;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl_unit
// Brief    : Directed vectors for pipe_ctrl_unit (MUL_LAT=4/EN_IMM=1 and
//            MUL_LAT=1/EN_IMM=0 instances).
// Revision : 1.0
// ============================================================================
module tb_pipe_ctrl_unit;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipe_ctrl_unit_if #(.ALU_OP_W(3)) ia ();
    pipe_ctrl_unit_if #(.ALU_OP_W(3)) ib ();

    pipe_ctrl_unit #(.ALU_OP_W(3), .MUL_LAT(4), .EN_IMM(1)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ia)
    );

    pipe_ctrl_unit #(.ALU_OP_W(3), .MUL_LAT(1), .EN_IMM(0)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ib)
    );

    // exp_id {branch, branch_n, jump, illegal}; exp_ex {reg_dst, alu_src, alu_op[2:0], mul}
    typedef struct {
        logic [5:0] op;
        logic [5:0] func;
        logic       no_op;
        logic       flush;
        logic [3:0] exp_id;
        logic [5:0] exp_ex;
        logic [1:0] exp_mem;
        logic [1:0] exp_wb;
    } vec_t;

    localparam int c_NV = 19;
    vec_t vecs [c_NV];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [5:0] op, input logic [5:0] fn, input logic nop, input logic fl);
        ia.op_code = op;
        ia.func    = fn;
        ia.no_op   = nop;
        ia.flush   = fl;
    endtask

    task automatic drive_b(input logic [5:0] op, input logic [5:0] fn, input logic nop, input logic fl);
        ib.op_code = op;
        ib.func    = fn;
        ib.no_op   = nop;
        ib.flush   = fl;
    endtask

    // {reg_dst, alu_src, alu_op[2:0], mul, mem_read, mem_write, wb_reg_write, wb_mem_to_reg, mul_stall}
    function automatic logic [10:0] obs_a();
        return {ia.ex_reg_dst, ia.ex_alu_src, ia.ex_alu_op, ia.ex_mul,
                ia.mem_read, ia.mem_write, ia.wb_reg_write, ia.wb_mem_to_reg, ia.mul_stall};
    endfunction

    function automatic logic [10:0] obs_b();
        return {ib.ex_reg_dst, ib.ex_alu_src, ib.ex_alu_op, ib.ex_mul,
                ib.mem_read, ib.mem_write, ib.wb_reg_write, ib.wb_mem_to_reg, ib.mul_stall};
    endfunction

    function automatic logic [10:0] id_a();
        return {7'b0, ia.id_branch, ia.id_branch_n, ia.id_jump, ia.id_illegal};
    endfunction

    function automatic logic [10:0] id_b();
        return {7'b0, ib.id_branch, ib.id_branch_n, ib.id_jump, ib.id_illegal};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] mexp [7];
        int k;

        vecs[0]  = '{6'h00, 6'h20, 1'b0, 1'b0, 4'b0000, 6'b1_0_010_0, 2'b00, 2'b10};
        vecs[1]  = '{6'h00, 6'h22, 1'b0, 1'b0, 4'b0000, 6'b1_0_010_0, 2'b00, 2'b10};
        vecs[2]  = '{6'h00, 6'h24, 1'b0, 1'b0, 4'b0000, 6'b1_0_010_0, 2'b00, 2'b10};
        vecs[3]  = '{6'h00, 6'h25, 1'b0, 1'b0, 4'b0000, 6'b1_0_010_0, 2'b00, 2'b10};
        vecs[4]  = '{6'h00, 6'h2A, 1'b0, 1'b0, 4'b0000, 6'b1_0_010_0, 2'b00, 2'b10};
        vecs[5]  = '{6'h23, 6'h20, 1'b0, 1'b0, 4'b0000, 6'b0_1_000_0, 2'b10, 2'b11};
        vecs[6]  = '{6'h2B, 6'h00, 1'b0, 1'b0, 4'b0000, 6'b0_1_000_0, 2'b01, 2'b00};
        vecs[7]  = '{6'h08, 6'h00, 1'b0, 1'b0, 4'b0000, 6'b0_1_000_0, 2'b00, 2'b10};
        vecs[8]  = '{6'h04, 6'h00, 1'b0, 1'b0, 4'b1000, 6'b0_0_001_0, 2'b00, 2'b00};
        vecs[9]  = '{6'h05, 6'h00, 1'b0, 1'b0, 4'b0100, 6'b0_0_001_0, 2'b00, 2'b00};
        vecs[10] = '{6'h02, 6'h00, 1'b0, 1'b0, 4'b0010, 6'b0_0_000_0, 2'b00, 2'b00};
        vecs[11] = '{6'h3F, 6'h20, 1'b0, 1'b0, 4'b0001, 6'b0_0_000_0, 2'b00, 2'b00};
        vecs[12] = '{6'h00, 6'h01, 1'b0, 1'b0, 4'b0001, 6'b0_0_000_0, 2'b00, 2'b00};
        vecs[13] = '{6'h00, 6'h20, 1'b1, 1'b0, 4'b0000, 6'b0_0_000_0, 2'b00, 2'b00};
        vecs[14] = '{6'h04, 6'h00, 1'b0, 1'b1, 4'b0000, 6'b0_0_000_0, 2'b00, 2'b00};
        vecs[15] = '{6'h05, 6'h00, 1'b1, 1'b0, 4'b0000, 6'b0_0_000_0, 2'b00, 2'b00};
        vecs[16] = '{6'h02, 6'h00, 1'b0, 1'b1, 4'b0000, 6'b0_0_000_0, 2'b00, 2'b00};
        vecs[17] = '{6'h23, 6'h00, 1'b0, 1'b1, 4'b0000, 6'b0_0_000_0, 2'b00, 2'b00};
        vecs[18] = '{6'h10, 6'h00, 1'b0, 1'b0, 4'b0001, 6'b0_0_000_0, 2'b00, 2'b00};

        rst = 1'b1;
        drive_a(6'h00, 6'h00, 1'b0, 1'b0);
        drive_b(6'h00, 6'h00, 1'b0, 1'b0);
        #2;
        chk("reset_a", obs_a(), 11'b0);
        chk("reset_b", obs_b(), 11'b0);
        drive_a(6'h04, 6'h00, 1'b0, 1'b0);
        #1;
        chk("reset_id_follow", id_a(), 11'b000_0000_1000);
        drive_a(6'h00, 6'h00, 1'b0, 1'b0);
        tick();
        #2 rst = 1'b0;
        tick();

        for (int i = 0; i < c_NV; i++) begin
            drive_a(vecs[i].op, vecs[i].func, vecs[i].no_op, vecs[i].flush);
            #1;
            chk($sformatf("vec%0d_id", i), id_a(), {7'b0, vecs[i].exp_id});
            tick();
            chk($sformatf("vec%0d_ex", i), obs_a(), {vecs[i].exp_ex, 5'b0});
            drive_a(6'h00, 6'h00, 1'b0, 1'b0);
            tick();
            chk($sformatf("vec%0d_mem", i), obs_a(), {6'b0, vecs[i].exp_mem, 3'b0});
            tick();
            chk($sformatf("vec%0d_wb", i), obs_a(), {8'b0, vecs[i].exp_wb, 1'b0});
        end

        // mult then add, with a held bubble request that must be ignored while stalled
        mexp[0] = 11'b00_010_1_00_00_1;
        mexp[1] = 11'b00_010_1_00_00_1;
        mexp[2] = 11'b00_010_1_00_00_1;
        mexp[3] = 11'b00_010_1_00_00_0;
        mexp[4] = 11'b10_010_0_00_00_0;
        mexp[5] = 11'b00_000_0_00_00_0;
        mexp[6] = 11'b00_000_0_00_10_0;
        drive_a(6'h00, 6'h18, 1'b0, 1'b0);
        for (int e = 0; e < 7; e++) begin
            tick();
            chk($sformatf("mult_add_e%0d", e + 1), obs_a(), mexp[e]);
            if (e == 0) drive_a(6'h00, 6'h20, 1'b1, 1'b0);
            if (e == 3) drive_a(6'h00, 6'h20, 1'b0, 1'b0);
            if (e == 4) drive_a(6'h00, 6'h00, 1'b0, 1'b0);
        end

        // back-to-back mults
        drive_a(6'h00, 6'h18, 1'b0, 1'b0);
        for (int e = 0; e < 4; e++) tick();
        chk("mult2_first_last", obs_a(), 11'b00_010_1_00_00_0);
        tick();
        chk("mult2_second_load", obs_a(), 11'b00_010_1_00_00_1);
        drive_a(6'h00, 6'h00, 1'b0, 1'b0);
        k = 0;
        while (ia.mul_stall && k < 10) begin
            tick();
            k++;
        end
        chk("mult2_stall_len", 11'(k), 11'd3);
        chk("mult2_last_cycle", obs_a(), 11'b00_010_1_00_00_0);
        tick();
        chk("mult2_drained", obs_a(), 11'b0);

        // asynchronous reset with lw sitting in EX/MEM
        tick();
        tick();
        drive_a(6'h23, 6'h00, 1'b0, 1'b0);
        tick();
        drive_a(6'h00, 6'h00, 1'b0, 1'b0);
        tick();
        chk("rst_pre_mem", obs_a(), 11'b00_000_0_10_00_0);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_a", obs_a(), 11'b0);
        drive_a(6'h05, 6'h00, 1'b0, 1'b0);
        #1;
        chk("rst_mid_id", id_a(), 11'b000_0000_0100);
        #1 rst = 1'b0;
        drive_a(6'h23, 6'h00, 1'b0, 1'b0);
        tick();
        drive_a(6'h00, 6'h00, 1'b0, 1'b0);
        tick();
        chk("rst_post_lw_mem", obs_a(), 11'b00_000_0_10_00_0);

        // MUL_LAT=1: consecutive mults never stall
        drive_b(6'h00, 6'h18, 1'b0, 1'b0);
        tick();
        chk("b_mult1", obs_b(), 11'b00_010_1_00_00_0);
        tick();
        chk("b_mult2", obs_b(), 11'b00_010_1_00_00_0);
        drive_b(6'h00, 6'h00, 1'b0, 1'b0);
        tick();
        chk("b_mult_done", obs_b(), 11'b0);

        // EN_IMM=0: addi is illegal and becomes a bubble
        drive_b(6'h08, 6'h00, 1'b0, 1'b0);
        #1;
        chk("b_addi_id", id_b(), 11'b000_0000_0001);
        tick();
        chk("b_addi_ex", obs_b(), 11'b0);
        drive_b(6'h00, 6'h00, 1'b0, 1'b0);
        tick();
        tick();
        chk("b_addi_wb", obs_b(), 11'b0);

        // EN_IMM=0 instance still decodes lw
        drive_b(6'h23, 6'h00, 1'b0, 1'b0);
        tick();
        chk("b_lw_ex", obs_b(), 11'b01_000_0_00_00_0);
        drive_b(6'h00, 6'h00, 1'b0, 1'b0);
        tick();
        tick();
        chk("b_lw_wb", obs_b(), 11'b00_000_0_00_11_0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
